// File: rtl/pipe_defs.sv
// Shared pipeline definitions: hazard FSM encodings, NOP instruction, register-zero id,
// and the bundled hazard control word used by the stall controller.
package pipe_defs;

  typedef enum logic {
    RUN    = 1'b0,
    MDWAIT = 1'b1
  } hz_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          REG_ZERO  = 0;
  localparam int          MDCNT_W   = 3;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic ex_hold;
    logic md_busy;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_PASS   = 6'b110000;
  localparam hz_ctrl_t CTRL_STALL  = 6'b000100;
  localparam hz_ctrl_t CTRL_FLUSH  = 6'b101100;
  localparam hz_ctrl_t CTRL_FREEZE = 6'b000011;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bus: ID/EX and IF/ID hazard inputs plus the pipeline steering outputs.
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5
);
  logic             IDEXMemRead;
  logic [REG_W-1:0] IDEXRegRt;
  logic [REG_W-1:0] IFIDRegRs;
  logic [REG_W-1:0] IFIDRegRt;
  logic             IFIDUsesRt;
  logic             BranchTaken;
  logic             MDStart;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             IDEXFlush;
  logic             EXHold;
  logic             MDBusy;

  modport master (
    output IDEXMemRead, IDEXRegRt, IFIDRegRs, IFIDRegRt, IFIDUsesRt, BranchTaken, MDStart,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXHold, MDBusy
  );

  modport slave (
    input  IDEXMemRead, IDEXRegRt, IFIDRegRs, IFIDRegRt, IFIDUsesRt, BranchTaken, MDStart,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXHold, MDBusy
  );
endinterface

// File: rtl/hazard_md_timer.sv
// Loadable down-counter with zero flag; shared with the MUL/DIV unit for its latency sequencing.
module hazard_md_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_cnt <= '0;
    else if (i_load)                r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-flush / MUL-DIV freeze sequencer for the 5-stage core.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush/MD-wait counters.
module hazard_stall_ctrl
  import pipe_defs::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int REG_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_stall_ctrl_if.slave   hif
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          StallCycles,
  output logic [31:0]          FlushCount,
  output logic [31:0]          MDWaitCycles
`endif
);
  // The MDStart cycle is itself the first frozen cycle, so the timer only tracks the
  // MDWAIT cycles that follow: MD_LATENCY-2 of them, for MD_LATENCY-1 frozen in total.
  localparam logic [MDCNT_W-1:0] MD_LOAD  = MDCNT_W'(MD_LATENCY - 2);
  localparam bit                 MD_WAITS = (MD_LATENCY > 2);

  hz_state_e          r_state, w_nxt;
  hz_ctrl_t           w_ctl;
  logic               w_load, w_dec, w_zero, w_lu;
  logic [MDCNT_W-1:0] w_cnt;

  hazard_md_timer #(.W(MDCNT_W)) u_md_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (MD_LOAD),
    .i_dec      (w_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_zero)
  );

  assign w_lu = hif.IDEXMemRead && (hif.IDEXRegRt != REG_W'(REG_ZERO)) &&
                ((hif.IDEXRegRt == hif.IFIDRegRs) ||
                 (hif.IFIDUsesRt && hif.IDEXRegRt == hif.IFIDRegRt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt  = r_state;
    w_ctl  = CTRL_PASS;
    w_load = 1'b0;
    w_dec  = 1'b0;
    case (r_state)
      RUN: begin
        // Branch first: anything younger in ID/EX (load consumer or MUL/DIV) is squashed.
        if (hif.BranchTaken) begin
          w_ctl = CTRL_FLUSH;
        end else if (hif.MDStart) begin
          w_ctl  = CTRL_FREEZE;
          w_load = 1'b1;
          w_nxt  = MD_WAITS ? MDWAIT : RUN;
        end else if (w_lu) begin
          w_ctl = CTRL_STALL;
        end
      end
      MDWAIT: begin
        w_dec = 1'b1;
        if (!w_zero)            w_ctl = CTRL_FREEZE;
        if (w_cnt <= 3'd1)      w_nxt = RUN;
      end
      default: w_nxt = RUN;
    endcase
  end

  assign hif.PCWrite   = w_ctl.pc_write;
  assign hif.IFIDWrite = w_ctl.ifid_write;
  assign hif.IFIDFlush = w_ctl.ifid_flush;
  assign hif.IDEXFlush = w_ctl.idex_flush;
  assign hif.EXHold    = w_ctl.ex_hold;
  assign hif.MDBusy    = w_ctl.md_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall, r_flush, r_mdwait;
  logic        w_flush_evt;

  assign w_flush_evt = (r_state == RUN) && hif.BranchTaken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall  <= '0;
      r_flush  <= '0;
      r_mdwait <= '0;
    end else begin
      if (!w_ctl.pc_write && r_stall  != '1) r_stall  <= r_stall + 32'd1;
      if (w_flush_evt     && r_flush  != '1) r_flush  <= r_flush + 32'd1;
      if (w_ctl.ex_hold   && r_mdwait != '1) r_mdwait <= r_mdwait + 32'd1;
    end
  end

  assign StallCycles  = r_stall;
  assign FlushCount   = r_flush;
  assign MDWaitCycles = r_mdwait;
`endif
endmodule
